// File: rtl/text_pixel_serializer.sv
// Text-mode pixel engine: coordinates -> text RAM -> character ROM -> serialized pixel,
// with a blinking block cursor and sync signals delayed to stay aligned with the pixels.
module text_pixel_serializer #(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 8,
    parameter int CHAR_CODES   = 41,
    parameter int TEXT_COLS    = 80,
    parameter int TEXT_ROWS    = 30,
    parameter int TEXT_AW      = 12,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [9:0]            i_pix_x,
    input  logic [9:0]            i_pix_y,
    input  logic                  i_video_on,
    input  logic                  i_hsync,
    input  logic                  i_vsync,
    input  logic                  i_frame_tick,
    output logic [TEXT_AW-1:0]    o_text_addr,
    input  logic [5:0]            i_char_code,
    output logic [ADDR_WIDTH-1:0] o_char_addr,
    input  logic [DATA_WIDTH-1:0] i_char_strip,
    input  logic                  i_cursor_en,
    input  logic [6:0]            i_cursor_col,
    input  logic [4:0]            i_cursor_row,
    output logic                  o_pixel,
    output logic                  o_video_on,
    output logic                  o_hsync,
    output logic                  o_vsync
);

    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BW-1:0]  blink_cnt_r;
    logic           blink_phase_r;

    // Per-pixel side information, index 0 = written at the first edge, index 3 = used at the last
    logic [3:0][2:0] x_lo_r;
    logic [1:0][3:0] y_lo_r;
    logic [3:0]      oob_r;
    logic [3:0]      hit_r;
    logic [3:0]      vid_r;
    logic [3:0]      hs_r;
    logic [3:0]      vs_r;
    logic [1:0]      bad_r;

    logic [6:0]         cell_col_s;
    logic [5:0]         cell_row_s;
    logic [TEXT_AW-1:0] text_addr_s;
    logic               oob_s;
    logic               hit_s;
    logic               bad_s;
    logic               pix_bit_s;
    logic               pixel_s;

    assign cell_col_s  = i_pix_x[9:3];
    assign cell_row_s  = i_pix_y[9:4];
    assign text_addr_s = TEXT_AW'(32'(cell_row_s) * 32'(TEXT_COLS) + 32'(cell_col_s));
    assign oob_s       = (32'(cell_col_s) >= 32'(TEXT_COLS)) || (32'(cell_row_s) >= 32'(TEXT_ROWS));
    assign hit_s       = i_cursor_en & (cell_col_s == i_cursor_col)
                       & (cell_row_s == {1'b0, i_cursor_row}) & blink_phase_r;
    assign bad_s       = 32'(i_char_code) >= 32'(CHAR_CODES);
    // MSB of the strip is the leftmost pixel of the glyph
    assign pix_bit_s   = i_char_strip[3'd7 - x_lo_r[3]];
    assign pixel_s     = vid_r[3] & ~oob_r[3] & ((pix_bit_s & ~bad_r[1]) ^ hit_r[3]);

    // Cursor blink counter; frame ticks during reset are dropped
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            blink_cnt_r   <= {BW{1'b0}};
            blink_phase_r <= 1'b0;
        end else if (i_frame_tick) begin
            if (blink_cnt_r == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt_r   <= {BW{1'b0}};
                blink_phase_r <= ~blink_phase_r;
            end else begin
                blink_cnt_r   <= blink_cnt_r + BW'(1);
            end
        end else begin
            blink_cnt_r   <= blink_cnt_r;
        end
    end

    // Five-stage fetch/serialize pipeline and aligned sync delay line
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_text_addr <= {TEXT_AW{1'b0}};
            o_char_addr <= {ADDR_WIDTH{1'b0}};
            o_pixel     <= 1'b0;
            o_video_on  <= 1'b0;
            o_hsync     <= 1'b1;
            o_vsync     <= 1'b1;
            x_lo_r      <= 12'd0;
            y_lo_r      <= 8'd0;
            oob_r       <= 4'd0;
            hit_r       <= 4'd0;
            vid_r       <= 4'd0;
            // Sync delay line idles high so a reset never emits a spurious sync pulse
            hs_r        <= 4'b1111;
            vs_r        <= 4'b1111;
            bad_r       <= 2'd0;
        end else begin
            o_text_addr <= text_addr_s;
            x_lo_r      <= {x_lo_r[2:0], i_pix_x[2:0]};
            y_lo_r      <= {y_lo_r[0], i_pix_y[3:0]};
            oob_r       <= {oob_r[2:0], oob_s};
            hit_r       <= {hit_r[2:0], hit_s};
            vid_r       <= {vid_r[2:0], i_video_on};
            hs_r        <= {hs_r[2:0], i_hsync};
            vs_r        <= {vs_r[2:0], i_vsync};
            o_char_addr <= ADDR_WIDTH'({i_char_code, y_lo_r[1]});
            bad_r       <= {bad_r[0], bad_s};
            o_pixel     <= pixel_s;
            o_video_on  <= vid_r[3];
            o_hsync     <= hs_r[3];
            o_vsync     <= vs_r[3];
        end
    end

endmodule

// File: tb/tb_text_pixel_serializer.sv
// Directed bench for text_pixel_serializer: behavioural text RAM / ROM, a per-step reference
// model computed straight from the screen contents, and a single compare process.
module tb_text_pixel_serializer;

    localparam int BLINK = 2;
    localparam int MAXS  = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [9:0]  pix_x = 10'd0;
    logic [9:0]  pix_y = 10'd0;
    logic        video_on = 1'b0;
    logic        hsync = 1'b1;
    logic        vsync = 1'b1;
    logic        frame_tick = 1'b0;
    logic [11:0] text_addr;
    logic [5:0]  char_code = 6'd0;
    logic [9:0]  char_addr;
    logic [7:0]  char_strip = 8'd0;
    logic        cursor_en = 1'b0;
    logic [6:0]  cursor_col = 7'd0;
    logic [4:0]  cursor_row = 5'd0;
    logic        pixel, video_on_o, hsync_o, vsync_o;

    logic [5:0] text_ram [4096];
    logic [7:0] rom      [1024];

    int tests = 0;
    int fails = 0;
    int step_cnt = 0;
    int m_cnt = 0;
    bit m_phase = 1'b0;

    bit h_rst [MAXS];
    bit h_pix [MAXS];
    bit h_vid [MAXS];
    bit h_hs  [MAXS];
    bit h_vs  [MAXS];
    int h_ta  [MAXS];
    int h_ca  [MAXS];
    int p_pix [MAXS];
    int p_ta  [MAXS];
    int p_ca  [MAXS];

    text_pixel_serializer #(.BLINK_FRAMES(BLINK)) dut (
        .i_clk(clk), .i_rst(rst), .i_pix_x(pix_x), .i_pix_y(pix_y),
        .i_video_on(video_on), .i_hsync(hsync), .i_vsync(vsync), .i_frame_tick(frame_tick),
        .o_text_addr(text_addr), .i_char_code(char_code), .o_char_addr(char_addr),
        .i_char_strip(char_strip), .i_cursor_en(cursor_en), .i_cursor_col(cursor_col),
        .i_cursor_row(cursor_row), .o_pixel(pixel), .o_video_on(video_on_o),
        .o_hsync(hsync_o), .o_vsync(vsync_o)
    );

    always #5 clk = ~clk;

    // Registered text RAM and character ROM, one cycle of read latency each
    always @(posedge clk) begin
        char_code  <= text_ram[text_addr];
        char_strip <= rom[char_addr];
    end

    task automatic chk(input string name, input int n, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at step %0d: got %0d, expected %0d", name, n, act, exp);
        end
    endtask

    // Compare process: outputs after edge n reflect the inputs of step n-4
    always @(posedge clk) begin
        int n;
        bit clean;
        #1;
        n = step_cnt - 1;
        if (n >= 0) begin
            if (h_rst[n]) begin
                chk("rst_pixel", n, int'(pixel), 0);
                chk("rst_hsync", n, int'(hsync_o), 1);
                chk("rst_vsync", n, int'(vsync_o), 1);
                chk("rst_video", n, int'(video_on_o), 0);
                chk("rst_text_addr", n, int'(text_addr), 0);
                chk("rst_char_addr", n, int'(char_addr), 0);
            end else begin
                chk("text_addr", n, int'(text_addr), h_ta[n]);
                if (p_ta[n] >= 0) chk("pin_text_addr", n, int'(text_addr), p_ta[n]);
                if (n >= 2 && !h_rst[n-1] && !h_rst[n-2]) begin
                    chk("char_addr", n, int'(char_addr), h_ca[n-2]);
                    if (p_ca[n-2] >= 0) chk("pin_char_addr", n, int'(char_addr), p_ca[n-2]);
                end
                clean = (n >= 4);
                for (int j = 1; j <= 4; j++) if (n - j >= 0 && h_rst[n-j]) clean = 1'b0;
                if (clean) begin
                    chk("pixel", n, int'(pixel), int'(h_pix[n-4]));
                    chk("hsync", n, int'(hsync_o), int'(h_hs[n-4]));
                    chk("vsync", n, int'(vsync_o), int'(h_vs[n-4]));
                    chk("video_on", n, int'(video_on_o), int'(h_vid[n-4]));
                    if (p_pix[n-4] >= 0) chk("pin_pixel", n, int'(pixel), p_pix[n-4]);
                end
            end
        end
    end

    // One pixel clock of stimulus: record the expected outputs, drive, wait for the next negedge
    task automatic step(input int x, input int y, input bit vid, input bit hs, input bit vs,
                        input bit tick, input bit r,
                        input int pp = -1, input int pt = -1, input int pc = -1);
        int k, col, row, ta, code, ylo;
        logic [7:0] strip;
        bit b, hit;
        k   = step_cnt;
        col = (x % 1024) / 8;
        row = (y % 1024) / 16;
        ylo = y % 16;
        ta  = (row * 80 + col) % 4096;
        code  = int'(text_ram[ta]);
        strip = rom[(code * 16 + ylo) % 1024];
        b   = strip[7 - (x % 8)];
        hit = cursor_en && (col == int'(cursor_col)) && (row == int'(cursor_row)) && m_phase;
        h_rst[k] = r;
        h_ta[k]  = ta;
        h_ca[k]  = code * 16 + ylo;
        h_pix[k] = vid && (col < 80) && (row < 30) && ((code >= 41 ? 1'b0 : b) ^ hit);
        h_vid[k] = vid;
        h_hs[k]  = hs;
        h_vs[k]  = vs;
        p_pix[k] = pp;
        p_ta[k]  = pt;
        p_ca[k]  = pc;
        if (r) begin
            m_cnt = 0;
            m_phase = 1'b0;
        end else if (tick) begin
            if (m_cnt == BLINK - 1) begin
                m_cnt = 0;
                m_phase = !m_phase;
            end else begin
                m_cnt++;
            end
        end
        pix_x = 10'(x); pix_y = 10'(y); video_on = vid; hsync = hs; vsync = vs;
        frame_tick = tick; rst = r;
        step_cnt++;
        @(negedge clk);
    endtask

    // A run of pixels on one scanline with an hsync pulse; optionally pins one 8-pixel cell
    task automatic run_line(input int y, input int x0, input int x1, input bit vid,
                            input int pin_x0, input logic [7:0] pat, input bit use_pin);
        logic [7:0] pv;
        pv = pat;
        for (int x = x0; x <= x1; x++) begin
            if (use_pin && x >= pin_x0 && x < pin_x0 + 8)
                step(x, y, vid, !(x >= x0 + 3 && x <= x0 + 5), 1'b1, 1'b0, 1'b0,
                     int'(pv[7 - (x - pin_x0)]));
            else
                step(x, y, vid, !(x >= x0 + 3 && x <= x0 + 5), 1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) text_ram[i] = 6'(i % 64);
        for (int i = 0; i < 1024; i++) rom[i] = 8'((i * 37 + 11) % 256);
        text_ram[161] = 6'd5;  text_ram[162] = 6'd5;  text_ram[163] = 6'd41;
        text_ram[2399] = 6'd9; text_ram[2400] = 6'd5;
        rom[5*16+3] = 8'hA1;   rom[5*16+4] = 8'h0F;   rom[5*16+5] = 8'hFF;
        rom[5*16+15] = 8'hFF;  rom[41*16+3] = 8'hFF;  rom[9*16+15] = 8'h3C;

        @(negedge clk);
        // Reset held 3 clocks with live inputs, one coincident frame tick
        step(17, 35, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        step(17, 35, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(17, 35, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(17, 35, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, -1, 162, 83);
        for (int i = 0; i < 4; i++) step(18 + i, 35, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        // Serialization of 8'hA1, then a bad code with an all-ones strip
        run_line(35, 0, 23, 1'b1, 8, 8'hA1, 1'b1);
        run_line(35, 24, 31, 1'b1, 24, 8'h00, 1'b1);
        // Blanked region with an all-ones strip
        run_line(37, 8, 15, 1'b0, 8, 8'h00, 1'b1);

        // Cursor blink on cell (2,2) with strip 8'h0F
        cursor_en = 1'b1; cursor_col = 7'd2; cursor_row = 5'd2;
        run_line(36, 0, 31, 1'b1, 16, 8'h0F, 1'b1);
        ticks(2);
        run_line(36, 0, 31, 1'b1, 16, 8'hF0, 1'b1);
        ticks(2);
        run_line(36, 0, 31, 1'b1, 16, 8'h0F, 1'b1);
        // Tick during reset is dropped: one further tick must not flip the phase
        step(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        ticks(1);
        run_line(36, 8, 31, 1'b1, 16, 8'h0F, 1'b1);
        ticks(1);
        run_line(36, 8, 31, 1'b1, 16, 8'hF0, 1'b1);
        cursor_en = 1'b0;

        // Bottom-right cell and the first column past the text area
        step(639, 479, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, -1, 2399);
        step(640, 479, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 6; i++) step(641 + i, 479, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of a line
        run_line(35, 0, 7, 1'b1, 0, 8'h00, 1'b0);
        step(8, 35, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        run_line(35, 9, 24, 1'b1, 0, 8'h00, 1'b0);

        // Mixed coordinates, cursor positions, ticks and occasional resets
        for (int i = 0; i < 400; i++) begin
            cursor_en  = 1'($urandom_range(0, 1));
            cursor_col = 7'($urandom_range(0, 6));
            cursor_row = 5'($urandom_range(0, 4));
            if (i % 4 == 0)
                step($urandom_range(0, 1023), $urandom_range(0, 1023), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 7) == 0), ($urandom_range(0, 63) == 0));
            else
                step($urandom_range(0, 55), $urandom_range(0, 79), 1'($urandom_range(0, 3) != 0),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 5) == 0), 1'b0);
        end
        for (int i = 0; i < 6; i++) step(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
